seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Parametrised multi-cycle adder/subtractor for the 64-bit ALU datapath, the sequential successor of the 8-bit ripple-carry adder. It splits a WIDTH-bit operation into WIDTH/CHUNK slices and processes one CHUNK-bit ripple slice per clock, keeping the carry in a register between slices. Operands enter through a valid/ready handshake, results leave through a second one. The block trades latency for a short combinational carry chain in the ALU's add/sub path.

## Interface
- WIDTH, 64: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits added per clock; 1 ≤ CHUNK ≤ WIDTH.
- Derived (not overridable): NCHUNK = WIDTH/CHUNK, CNT_W = max(1, clog2(NCHUNK)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: z = x + y + c_in; 1: z = x − y − c_in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch x, y_eff = sub ? ~y : y, carry = sub ? ~c_in : c_in, and sub into internal registers. Clear z and the chunk counter k. Go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add slice k: x[k·CHUNK +: CHUNK] + y_eff[same] + carry.
  - Write the sum into z[same] and the slice carry-out into carry. Then k++.
  - After the slice with k = NCHUNK−1, go to DONE.
  - Set c_out = final carry.
  - Set ovf = (x[MSB] == y_eff[MSB]) & (z[MSB] != x[MSB]), using the final z.
- DONE:
  - out_valid=1.
  - z, c_out and ovf are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE.
  - No new operands are accepted in DONE. There is no same-cycle pass-through from DONE to RUN.
- Inputs x, y, c_in and sub are sampled only at the accept edge. Later changes are ignored.
- in_valid while not in_ready: ignored. The source must hold it until accepted.
- Reset, asynchronous, at any time including mid-RUN:
  - state=IDLE, k=0, z=0, c_out=0, ovf=0, out_valid=0, internal carry=0.
  - in_ready=1 while in reset and after release.
  - Any in-flight operation is discarded, with no partial out_valid.
- Outputs in_ready and out_valid are decoded from the state register only, not combinationally from inputs.
- z is internal while in RUN and may show partial slices. Consumers sample it only when out_valid=1.

## Timing
- Accept edge = edge 0. Slices are processed on edges 1..NCHUNK.
- out_valid goes high after edge NCHUNK.
- Latency from accept to out_valid: NCHUNK cycles (8 at the defaults).
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high (accept, NCHUNK RUN cycles, DONE handshake, IDLE).
- NCHUNK=1: a single RUN cycle, so out_valid comes one cycle after accept.
- Critical path: one CHUNK-bit ripple chain plus the carry register.

## Structure
- Package seq_chunk_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a helper function for the signed-overflow expression.
- Sub-module rca_slice, parametrised by CHUNK:
  - purely combinational ripple-carry slice;
  - ports: a, b, ci, s, co.
  - Instantiated once and reused every RUN cycle via an indexed part-select.
- Elaboration-time check: WIDTH % CHUNK == 0. A failure is a fatal error.

## Test plan
- Add, carry wrap (defaults): x=0xFFFF_FFFF_FFFF_FFFF, y=1, c_in=0, sub=0 → z=0, c_out=1, ovf=0; out_valid exactly 8 cycles after accept.
- Signed overflow: x=0x7FFF_FFFF_FFFF_FFFF, y=0, c_in=1, sub=0 → z=0x8000_0000_0000_0000, c_out=0, ovf=1.
- Subtract with borrow: x=5, y=7, c_in=0, sub=1 → z=0xFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0. Then x=7, y=5, c_in=1 → z=1, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → z, c_out and ovf stay stable; in_ready=0; a pulsed in_valid with new operands is ignored. Raising out_ready gives IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 asynchronously at slice k=3 → all outputs 0 immediately, in_ready=1, no out_valid. A following operation (x=1, y=2) yields z=3.
- Parameter sweep:
  - WIDTH=8/CHUNK=8 (1-cycle latency), WIDTH=16/CHUNK=1 (16-cycle latency), WIDTH=64/CHUNK=16.
  - 1000 random (x, y, c_in, sub) per configuration, with random out_ready stalls.
  - All results are checked against {c_out, z} = x ± y ± c_in computed at WIDTH+1 bits.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the sequential chunked adder/subtractor.
// Contents: controller state encoding and the signed-overflow predicate.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple-carry slice.
// Ports: a, b - slice operands; ci - carry in; s - slice sum; co - carry out.
module rca_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] sum;

  assign sum = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(ci);
  assign s   = sum[CHUNK-1:0];
  assign co  = sum[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry kept
// in a register between slices, valid/ready handshake on both sides.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with operands
// x, y, c_in, sub; out_valid/out_ready with result z, c_out, ovf.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  // Reject configurations that do not split into whole slices.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $fatal(1, "seq_chunk_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic               carry;
  logic [CNT_W-1:0]   k;
  logic               last;
  logic [CHUNK-1:0]   a_sl;
  logic [CHUNK-1:0]   b_sl;
  logic [CHUNK-1:0]   s_sl;
  logic               co_sl;

  assign last = (k == LAST);
  assign a_sl = x_q[32'(k) * CHUNK +: CHUNK];
  assign b_sl = y_q[32'(k) * CHUNK +: CHUNK];

  // Single slice adder shared by every RUN cycle.
  rca_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .s  (s_sl),
    .co (co_sl)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Handshake flags registered so they always equal the state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  // Operand capture and slice-by-slice accumulation. Subtraction is
  // folded into addition of ~y with inverted carry-in at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      carry <= 1'b0;
      k     <= '0;
      z     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= x;
            y_q   <= sub ? ~y : y;
            carry <= sub ? ~c_in : c_in;
            z     <= '0;
            k     <= '0;
          end
        end
        RUN: begin
          z[32'(k) * CHUNK +: CHUNK] <= s_sl;
          carry <= co_sl;
          k     <= k + CNT_W'(1);
          if (last) begin
            c_out <= co_sl;
            // Final MSB of z is the top bit of the slice being written now.
            ovf   <= ovf_calc(x_q[WIDTH-1], y_q[WIDTH-1], s_sl[CHUNK-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder over four WIDTH/CHUNK configurations.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int unsigned W = (g == 1) ? 8 : (g == 2) ? 16 : 64;
    localparam int unsigned C = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 1 : 16;
    localparam int unsigned N = W / C;

    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         c_in      = 1'b0;
    logic         sub       = 1'b0;
    logic         dir_ready = 1'b0;
    logic         rnd_ready = 1'b0;
    bit           rnd_mode  = 1'b0;
    bit           fin       = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [W-1:0] z;
    logic         in_ready, out_valid, c_out, ovf, out_ready;

    assign out_ready = rnd_mode ? rnd_ready : dir_ready;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .c_out     (c_out),
      .ovf       (ovf)
    );

    // Reference arithmetic: {ovf, c_out, z} from plain wide integer math.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic s);
      logic [W+1:0] ua, ub, ur, sa, sb, sr;
      logic         cy;
      ua = {2'b00, a};
      ub = {2'b00, b};
      sa = {{2{a[W-1]}}, a};
      sb = {{2{b[W-1]}}, b};
      if (!s) begin
        ur = ua + ub + (W+2)'(ci);
        sr = sa + sb + (W+2)'(ci);
        cy = ur[W];
      end else begin
        ur = ua - ub - (W+2)'(ci);
        sr = sa - sb - (W+2)'(ci);
        cy = !ur[W+1];
      end
      return {(sr[W] != sr[W-1]), cy, ur[W-1:0]};
    endfunction

    // Transaction model: one operation in flight, result due N edges after accept.
    bit           have_op = 1'b0;
    int           cyc     = 0;
    int           acc     = 0;
    logic [W+1:0] exp_res = '0;
    wire          exp_valid = have_op && ((cyc - acc) >= int'(N));

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        have_op <= 1'b0;
      end else begin
        cyc <= cyc + 1;
        if (exp_valid && out_ready) begin
          have_op <= 1'b0;
        end else if (!have_op && in_valid) begin
          have_op <= 1'b1;
          acc     <= cyc + 1;
          exp_res <= model(x, y, c_in, sub);
        end
      end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
      if (!rst_n) begin
        check($sformatf("cfg%0d_rst_in_ready", g), 128'(in_ready), 128'(1));
        check($sformatf("cfg%0d_rst_out_valid", g), 128'(out_valid), 128'(0));
        check($sformatf("cfg%0d_rst_z", g), 128'(z), 128'(0));
      end else begin
        check($sformatf("cfg%0d_in_ready", g), 128'(in_ready), 128'(!have_op));
        check($sformatf("cfg%0d_out_valid", g), 128'(out_valid), 128'(exp_valid));
        if (exp_valid) begin
          check($sformatf("cfg%0d_z", g), 128'(z), 128'(exp_res[W-1:0]));
          check($sformatf("cfg%0d_c_out", g), 128'(c_out), 128'(exp_res[W]));
          check($sformatf("cfg%0d_ovf", g), 128'(ovf), 128'(exp_res[W+1]));
        end
      end
    end

    always @(negedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    // Present operands (called just after a negedge); returns one negedge after accept.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s);
      int t;
      t        = 0;
      x        = a;
      y        = b;
      c_in     = ci;
      sub      = s;
      in_valid = 1'b1;
      while (!in_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check($sformatf("cfg%0d_accept_timeout", g), 128'(in_ready), 128'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      x        = W'({$urandom, $urandom});
      y        = W'({$urandom, $urandom});
      c_in     = 1'($urandom);
      sub      = 1'($urandom);
    endtask

    task automatic get(output int lat);
      lat = 0;
      while (!out_valid && lat < 1000) begin
        @(negedge clk);
        lat++;
      end
    endtask

    task automatic ack();
      dir_ready = 1'b1;
      @(negedge clk);
      dir_ready = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] ez, input logic ec, input logic eo);
      check($sformatf("cfg%0d_%s_z", g, tag), 128'(z), 128'(ez));
      check($sformatf("cfg%0d_%s_c_out", g, tag), 128'(c_out), 128'(ec));
      check($sformatf("cfg%0d_%s_ovf", g, tag), 128'(ovf), 128'(eo));
    endtask

    task automatic directed();
      int           lat;
      logic [W-1:0] ones, maxpos, minneg;
      ones   = '1;
      maxpos = ones >> 1;
      minneg = ~maxpos;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check($sformatf("cfg%0d_post_rst_in_ready", g), 128'(in_ready), 128'(1));
      check($sformatf("cfg%0d_post_rst_c_out", g), 128'(c_out), 128'(0));

      // All-ones + 1 wraps to zero with carry out.
      send(ones, W'(1), 1'b0, 1'b0);
      get(lat);
      check($sformatf("cfg%0d_latency", g), 128'(lat), 128'(N));
      expect_res("wrap", '0, 1'b1, 1'b0);
      ack();

      // Max positive + carry-in overflows into the sign bit.
      send(maxpos, '0, 1'b1, 1'b0);
      get(lat);
      expect_res("sovf", minneg, 1'b0, 1'b1);
      ack();

      // 5 - 7 borrows; 7 - 5 - 1 does not.
      send(W'(5), W'(7), 1'b0, 1'b1);
      get(lat);
      expect_res("sub57", ~W'(1), 1'b0, 1'b0);
      ack();
      send(W'(7), W'(5), 1'b1, 1'b1);
      get(lat);
      expect_res("sub75", W'(1), 1'b1, 1'b0);
      ack();

      // Backpressure: -1 + 0x24 = 0x23 with carry; a stray in_valid is ignored.
      send(ones, W'(8'h24), 1'b0, 1'b0);
      get(lat);
      for (int i = 0; i < 5; i++) begin
        expect_res("hold", W'(8'h23), 1'b1, 1'b0);
        check($sformatf("cfg%0d_hold_in_ready", g), 128'(in_ready), 128'(0));
        check($sformatf("cfg%0d_hold_out_valid", g), 128'(out_valid), 128'(1));
        in_valid = (i == 1);
        x        = ones;
        y        = ones;
        @(negedge clk);
      end
      ack();
      check($sformatf("cfg%0d_idle_after_ack", g), 128'(in_ready), 128'(1));
      check($sformatf("cfg%0d_no_valid_after_ack", g), 128'(out_valid), 128'(0));

      // Asynchronous reset three slices into an operation.
      send(ones, ones, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      expect_res("midrst", '0, 1'b0, 1'b0);
      check($sformatf("cfg%0d_midrst_in_ready", g), 128'(in_ready), 128'(1));
      check($sformatf("cfg%0d_midrst_out_valid", g), 128'(out_valid), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(W'(1), W'(2), 1'b0, 1'b0);
      get(lat);
      check($sformatf("cfg%0d_after_rst_latency", g), 128'(lat), 128'(N));
      expect_res("after_rst", W'(3), 1'b0, 1'b0);
      ack();
    endtask

    initial begin
      int t;
      directed();
      rnd_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(W'({$urandom, $urandom}), W'({$urandom, $urandom}), 1'($urandom), 1'($urandom));
      end
      t = 0;
      while (have_op && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (have_op) check($sformatf("cfg%0d_drain_timeout", g), 128'(have_op), 128'(0));
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60000) check("global_timeout", 128'(t), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
